// File: rtl/mmio_responder_if.sv
// CPU data-port and byte-drain signals for mmio_responder.
// The slave modport is the responder side; the master modport is the CPU/sink side.
interface mmio_responder_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        irq;

    modport slave (
        input  MemWrite, ALUResult, WriteData, out_ready,
        output ReadData, sel, out_valid, out_data, irq
    );

    modport master (
        output MemWrite, ALUResult, WriteData, out_ready,
        input  ReadData, sel, out_valid, out_data, irq
    );
endinterface

// File: rtl/mmio_responder.sv
// MMIO peripheral on the CPU data port: byte-output FIFO with ready/valid drain,
// free-running timer with compare match, and a level interrupt.
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMER_W    = 32
) (
    input logic               clk,
    input logic               reset,
    mmio_responder_if.slave   bus
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [5:0] OffTxdata = 6'h00;
    localparam logic [5:0] OffStatus = 6'h01;
    localparam logic [5:0] OffTimer  = 6'h02;
    localparam logic [5:0] OffTcmp   = 6'h03;
    localparam logic [5:0] OffCtrl   = 6'h04;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               match_q, match_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] tcmp_q, tcmp_d;
    logic               ten_q, ten_d;
    logic               ie_q, ie_d;

    logic [5:0]  offset;
    logic        wr_en;
    logic        push, push_ok, pop;
    logic        empty, full;
    logic        match_set, ovf_set;
    logic [31:0] status;
    logic [31:0] rdata;
    logic        unused_addr_lsb;

    // Byte lanes of the address are irrelevant: every register is a full word.
    assign unused_addr_lsb = ^bus.ALUResult[1:0];

    assign bus.sel = (bus.ALUResult[31:8] == BASE_ADDR[31:8]);
    assign offset  = bus.ALUResult[7:2];
    assign wr_en   = bus.MemWrite & bus.sel;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign pop     = bus.out_valid & bus.out_ready;
    assign push    = wr_en & (offset == OffTxdata);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    assign match_set = ten_q & (timer_q == tcmp_q);

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.irq       = ie_q & match_q;

    always_comb begin
        status       = '0;
        status[0]    = empty;
        status[1]    = full;
        status[2]    = ovf_q;
        status[3]    = match_q;
        status[11:8] = 4'(count_q);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Sticky flags: a hardware set beats a CPU clear in the same cycle.
    always_comb begin
        ovf_d   = ovf_q;
        match_d = match_q;
        if (wr_en && offset == OffStatus) begin
            if (bus.WriteData[2]) ovf_d = 1'b0;
            if (bus.WriteData[3]) match_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (match_set) match_d = 1'b1;
    end

    always_comb begin
        timer_d = timer_q;
        tcmp_d  = tcmp_q;
        ten_d   = ten_q;
        ie_d    = ie_q;
        if (wr_en && offset == OffTimer) begin
            timer_d = bus.WriteData[TIMER_W-1:0];
        end else if (ten_q) begin
            timer_d = timer_q + TIMER_W'(1);
        end
        if (wr_en && offset == OffTcmp) begin
            tcmp_d = bus.WriteData[TIMER_W-1:0];
        end
        if (wr_en && offset == OffCtrl) begin
            ten_d = bus.WriteData[0];
            ie_d  = bus.WriteData[1];
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.sel) begin
            case (offset)
                OffStatus: rdata = status;
                OffTimer:  rdata = 32'(timer_q);
                OffTcmp:   rdata = 32'(tcmp_q);
                OffCtrl:   rdata = {30'd0, ie_q, ten_q};
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.ReadData = rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            match_q  <= 1'b0;
            timer_q  <= '0;
            tcmp_q   <= '1;
            ten_q    <= 1'b0;
            ie_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= bus.WriteData[7:0];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            match_q  <= match_d;
            timer_q  <= timer_d;
            tcmp_q   <= tcmp_d;
            ten_q    <= ten_d;
            ie_q     <= ie_d;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: FIFO fill/drain/overflow, timer match and irq,
// address decode and asynchronous reset, with hand-computed expectations.
module tb_mmio_responder;

    localparam logic [31:0] ATx   = 32'hFFFF_0000;
    localparam logic [31:0] ASt   = 32'hFFFF_0004;
    localparam logic [31:0] ATim  = 32'hFFFF_0008;
    localparam logic [31:0] ACmp  = 32'hFFFF_000C;
    localparam logic [31:0] ACtrl = 32'hFFFF_0010;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] rv;

    mmio_responder_if bus ();

    mmio_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.ALUResult = addr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.ALUResult = addr;
        #1;
        data = bus.ReadData;
    endtask

    initial begin
        logic [7:0] exp_bytes [4];
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = '0;
        bus.WriteData = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        rd(ASt, rv);  chk("rst_status", rv, 32'h0000_0001);
        rd(ACmp, rv); chk("rst_tcmp", rv, 32'hFFFF_FFFF);
        rd(ATim, rv); chk("rst_timer", rv, 32'h0);
        reset = 1'b1;
        tick();

        // Fill past full: 0x45 dropped, OVF set
        for (int i = 0; i < 5; i++) wr(ATx, 32'h41 + 32'(i));
        rd(ASt, rv); chk("fill_status", rv, 32'h0000_0406);
        rd(ATx, rv); chk("txdata_read", rv, 32'h0);

        // Drain
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data", 32'(bus.out_data), 32'h41 + 32'(i));
            tick();
        end
        chk("drain_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_empty_data", 32'(bus.out_data), 32'h0);
        rd(ASt, rv); chk("drain_status", rv, 32'h0000_0005);
        bus.out_ready = 1'b0;
        wr(ASt, 32'h4);
        rd(ASt, rv); chk("ovf_clear", rv, 32'h0000_0001);

        // Full + push + pop
        for (int i = 0; i < 4; i++) wr(ATx, 32'h11 + 32'(i));
        bus.out_ready = 1'b1;
        wr(ATx, 32'h55);
        rd(ASt, rv); chk("fpp_status", rv, 32'h0000_0402);
        exp_bytes[0] = 8'h12; exp_bytes[1] = 8'h13;
        exp_bytes[2] = 8'h14; exp_bytes[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            chk("fpp_data", 32'(bus.out_data), 32'(exp_bytes[i]));
            tick();
        end
        chk("fpp_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Timer compare and irq
        wr(ACmp, 32'd10);
        rd(ACmp, rv); chk("tcmp_rw", rv, 32'd10);
        wr(ATim, 32'd0);
        wr(ACtrl, 32'h3);
        rd(ATim, rv); chk("tim_start", rv, 32'd0);
        repeat (10) tick();
        rd(ATim, rv); chk("tim_at_cmp", rv, 32'd10);
        chk("irq_before", 32'(bus.irq), 32'd0);
        tick();
        chk("irq_set", 32'(bus.irq), 32'd1);
        rd(ASt, rv); chk("match_status", rv, 32'h0000_0009);
        wr(ASt, 32'h8);
        chk("irq_clear", 32'(bus.irq), 32'd0);
        rd(ATim, rv); chk("tim_run", rv, 32'd12);
        wr(ATim, 32'd100);
        rd(ATim, rv); chk("tim_write_wins", rv, 32'd100);
        wr(ACmp, 32'd102);
        tick();
        wr(ASt, 32'h8);
        rd(ASt, rv); chk("match_set_wins", rv, 32'h0000_0009);
        chk("irq_set_wins", 32'(bus.irq), 32'd1);

        // Asynchronous reset mid-activity
        wr(ATx, 32'h66);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", 32'(bus.out_data), 32'h0);
        chk("arst_irq", 32'(bus.irq), 32'd0);
        rd(ASt, rv);   chk("arst_status", rv, 32'h0000_0001);
        rd(ACmp, rv);  chk("arst_tcmp", rv, 32'hFFFF_FFFF);
        rd(ACtrl, rv); chk("arst_ctrl", rv, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Decode
        rd(32'hFFFF_0014, rv); chk("unmapped_read", rv, 32'h0);
        chk("sel_in", 32'(bus.sel), 32'd1);
        bus.ALUResult = 32'hFFFF_0100;
        #1;
        chk("sel_above", 32'(bus.sel), 32'd0);
        bus.ALUResult = 32'h0000_0040;
        #1;
        chk("sel_low", 32'(bus.sel), 32'd0);
        wr(32'h0000_0008, 32'h1234);
        wr(32'h0000_0010, 32'h3);
        wr(32'h0000_0000, 32'h99);
        wr(32'h0000_0040, 32'hFFFF_FFFF);
        wr(32'hFFFF_0014, 32'hFFFF_FFFF);
        rd(ATim, rv);  chk("out_win_timer", rv, 32'h0);
        rd(ACtrl, rv); chk("out_win_ctrl", rv, 32'h0);
        rd(ASt, rv);   chk("out_win_status", rv, 32'h0000_0001);
        wr(ACtrl, 32'hFFFF_FFF2);
        rd(ACtrl, rv); chk("ctrl_mask", rv, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
